wired_tl_ram_device: RTL and testbench

- TileLink-UL device-side responder that terminates the A channel issued by the core's host port and returns D-channel responses.
- Backed by an internal 128-bit-wide register array.
- Used as a boot RAM / scratchpad and as the bench-side partner for the core's memory bus.
- Single outstanding transaction; programmable response wait-states to stress host-side backpressure handling.

---
 rtl/wired_tl_ram_device_if.sv | 42 ++++
 rtl/wired_tl_ram_device.sv | 143 ++++++++++++++
 tb/tb_wired_tl_ram_device.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wired_tl_ram_device_if.sv
// TileLink-UL A/D channel bundle between a host port and a device responder.
// master = host side (drives A, d_ready); slave = device side.
interface wired_tl_ram_device_if #(
    parameter int SOURCE_WIDTH = 1,
    parameter int SINK_WIDTH   = 1
);
    logic                    a_valid;
    logic                    a_ready;
    logic [2:0]              a_opcode;
    logic [2:0]              a_param;
    logic [2:0]              a_size;
    logic [SOURCE_WIDTH-1:0] a_source;
    logic [31:0]             a_address;
    logic [15:0]             a_mask;
    logic [127:0]            a_data;
    logic                    a_corrupt;

    logic                    d_valid;
    logic                    d_ready;
    logic [2:0]              d_opcode;
    logic [1:0]              d_param;
    logic [2:0]              d_size;
    logic [SOURCE_WIDTH-1:0] d_source;
    logic [SINK_WIDTH-1:0]   d_sink;
    logic                    d_denied;
    logic [127:0]            d_data;
    logic                    d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        input  d_ready
    );
endinterface

// File: rtl/wired_tl_ram_device.sv
// TileLink-UL RAM responder backed by a 128-bit word array, one transaction in flight.
// Latency: d_valid rises 1+RESP_DELAY cycles after the A handshake.
// Backpressure: a_ready low from acceptance until the D handshake; d_* held while d_ready is low.
module wired_tl_ram_device #(
    parameter int          SOURCE_WIDTH = 1,
    parameter int          SINK_WIDTH   = 1,
    parameter int          DEPTH        = 64,
    parameter logic [31:0] BASE_ADDR    = 32'h1C00_0000,
    parameter int          RESP_DELAY   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wired_tl_ram_device_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = IDX_W + 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  r_state;
    logic                    r_a_ready;
    logic                    r_d_valid;
    logic [2:0]              r_d_opcode;
    logic [2:0]              r_d_size;
    logic [SOURCE_WIDTH-1:0] r_d_source;
    logic                    r_d_denied;
    logic                    r_d_corrupt;
    logic [127:0]            r_d_data;
    logic [3:0]              r_cnt;
    logic [127:0]            r_mem [DEPTH];

    logic             w_accept;
    logic             w_is_get;
    logic             w_is_put;
    logic             w_in_range;
    logic             w_aligned;
    logic             w_size_ok;
    logic             w_denied;
    logic [3:0]       w_align_mask;
    logic [IDX_W-1:0] w_idx;
    logic             w_unused_ok;

    assign w_accept   = bus.a_valid && r_a_ready;
    assign w_is_get   = (bus.a_opcode == 3'd4);
    assign w_is_put   = (bus.a_opcode == 3'd0) || (bus.a_opcode == 3'd1);
    assign w_size_ok  = (bus.a_size <= 3'd4);
    // Base is aligned to the array span, so range check is an upper-bit compare.
    assign w_in_range = (bus.a_address[31:OFF_W] == BASE_ADDR[31:OFF_W]);
    assign w_idx      = bus.a_address[4 +: IDX_W];

    always_comb begin
        w_align_mask = 4'hF;
        case (bus.a_size)
            3'd0:    w_align_mask = 4'h0;
            3'd1:    w_align_mask = 4'h1;
            3'd2:    w_align_mask = 4'h3;
            3'd3:    w_align_mask = 4'h7;
            default: w_align_mask = 4'hF;
        endcase
    end

    assign w_aligned   = ((bus.a_address[3:0] & w_align_mask) == 4'h0);
    assign w_denied    = !(w_is_get || w_is_put) || !w_size_ok || !w_aligned || !w_in_range;
    assign w_unused_ok = ^{bus.a_param, bus.a_corrupt};

    // Corrupt write data is still committed; only the lane mask gates bytes.
    always_ff @(posedge clk) begin
        if (w_accept && w_is_put && !w_denied) begin
            for (int i = 0; i < 16; i++) begin
                if (bus.a_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.a_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a_ready   <= 1'b1;
            r_d_valid   <= 1'b0;
            r_d_opcode  <= 3'd0;
            r_d_size    <= 3'd0;
            r_d_source  <= '0;
            r_d_denied  <= 1'b0;
            r_d_corrupt <= 1'b0;
            r_d_data    <= '0;
            r_cnt       <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.a_valid) begin
                        r_d_opcode  <= w_is_get ? 3'd1 : 3'd0;
                        r_d_size    <= bus.a_size;
                        r_d_source  <= bus.a_source;
                        r_d_denied  <= w_denied;
                        r_d_corrupt <= w_is_get && w_denied;
                        r_d_data    <= (w_is_get && !w_denied) ? r_mem[w_idx] : '0;
                        r_a_ready   <= 1'b0;
                        if (RESP_DELAY > 0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(RESP_DELAY - 1);
                        end else begin
                            r_state   <= S_RESP;
                            r_d_valid <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= S_RESP;
                        r_d_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.d_ready) begin
                        r_state   <= S_IDLE;
                        r_d_valid <= 1'b0;
                        r_a_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_d_valid <= 1'b0;
                    r_a_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.a_ready   = r_a_ready;
    assign bus.d_valid   = r_d_valid;
    assign bus.d_opcode  = r_d_opcode;
    assign bus.d_param   = 2'd0;
    assign bus.d_size    = r_d_size;
    assign bus.d_source  = r_d_source;
    assign bus.d_sink    = '0;
    assign bus.d_denied  = r_d_denied;
    assign bus.d_data    = r_d_data;
    assign bus.d_corrupt = r_d_corrupt;
endmodule

// File: tb/tb_wired_tl_ram_device.sv
// Directed bench for wired_tl_ram_device: vector table on a zero-delay instance,
// plus wait-state, back-to-back and async-reset sequences.
module tb_wired_tl_ram_device;
    localparam logic [31:0] B = 32'h1C00_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wired_tl_ram_device_if #(.SOURCE_WIDTH(1), .SINK_WIDTH(1)) b0 ();
    wired_tl_ram_device_if #(.SOURCE_WIDTH(1), .SINK_WIDTH(1)) b3 ();

    wired_tl_ram_device #(.RESP_DELAY(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    wired_tl_ram_device #(.RESP_DELAY(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    typedef struct {
        logic [2:0]   op;
        logic [2:0]   sz;
        logic         src;
        logic [31:0]  addr;
        logic [15:0]  mask;
        logic [127:0] data;
        logic         cin;
        logic [2:0]   e_op;
        logic         e_den;
        logic         e_cor;
        logic [127:0] e_data;
    } vec_t;

    localparam logic [127:0] D1  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] W2  = 128'h0123456789ABCDEF01234567FFFFFFFF;
    localparam logic [127:0] D2  = 128'hDEADBEEFCAFEF00D0BADC0DE13579BDF;
    localparam logic [127:0] D3  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] D3P = 128'h00112233445566778899AABBCCDD5AFF;
    localparam logic [127:0] FF  = {128{1'b1}};

    vec_t vt [18];

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] sz, input logic src,
                                input logic [31:0] addr, input logic [15:0] mask,
                                input logic [127:0] data, input logic cin, input logic [2:0] eop,
                                input logic eden, input logic ecor, input logic [127:0] edata);
        vec_t v;
        v.op = op; v.sz = sz; v.src = src; v.addr = addr; v.mask = mask; v.data = data;
        v.cin = cin; v.e_op = eop; v.e_den = eden; v.e_cor = ecor; v.e_data = edata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive0(input vec_t v);
        b0.a_valid   = 1'b1;
        b0.a_opcode  = v.op;
        b0.a_size    = v.sz;
        b0.a_source  = v.src;
        b0.a_address = v.addr;
        b0.a_mask    = v.mask;
        b0.a_data    = v.data;
        b0.a_corrupt = v.cin;
    endtask

    task automatic txn0(input vec_t v, input int k);
        int n;
        @(negedge clk);
        drive0(v);
        n = 0;
        while (!b0.a_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d a_ready", k), b0.a_ready, 1);
        @(negedge clk);
        b0.a_valid = 1'b0;
        chk($sformatf("v%0d d_valid_lat1", k), b0.d_valid, 1);
        chk($sformatf("v%0d d_opcode", k), b0.d_opcode, v.e_op);
        chk($sformatf("v%0d d_denied", k), b0.d_denied, v.e_den);
        chk($sformatf("v%0d d_corrupt", k), b0.d_corrupt, v.e_cor);
        chk($sformatf("v%0d d_data", k), b0.d_data, v.e_data);
        chk($sformatf("v%0d d_source", k), b0.d_source, v.src);
        chk($sformatf("v%0d d_size", k), b0.d_size, v.sz);
        b0.d_ready = 1'b1;
        @(negedge clk);
        b0.d_ready = 1'b0;
    endtask

    task automatic txn3(input vec_t v, input int hold);
        int lat;
        logic [159:0] snap;
        @(negedge clk);
        b3.a_valid   = 1'b1;
        b3.a_opcode  = v.op;
        b3.a_size    = v.sz;
        b3.a_source  = v.src;
        b3.a_address = v.addr;
        b3.a_mask    = v.mask;
        b3.a_data    = v.data;
        b3.a_corrupt = v.cin;
        chk("d3 a_ready_idle", b3.a_ready, 1);
        lat = 0;
        do begin
            @(negedge clk);
            b3.a_valid = 1'b0;
            lat++;
            chk("d3 a_ready_busy", b3.a_ready, 0);
        end while (!b3.d_valid && lat < 20);
        chk("d3 latency", lat, 4);
        chk("d3 d_opcode", b3.d_opcode, v.e_op);
        chk("d3 d_denied", b3.d_denied, v.e_den);
        chk("d3 d_data", b3.d_data, v.e_data);
        chk("d3 d_source", b3.d_source, v.src);
        snap = {b3.d_valid, b3.d_opcode, b3.d_param, b3.d_size, b3.d_source, b3.d_sink,
                b3.d_denied, b3.d_corrupt, b3.d_data};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("d3 hold_stable", {b3.d_valid, b3.d_opcode, b3.d_param, b3.d_size, b3.d_source,
                                   b3.d_sink, b3.d_denied, b3.d_corrupt, b3.d_data}, snap);
            chk("d3 hold_a_ready", b3.a_ready, 0);
        end
        b3.d_ready = 1'b1;
        @(negedge clk);
        b3.d_ready = 1'b0;
        chk("d3 a_ready_after", b3.a_ready, 1);
        chk("d3 d_valid_after", b3.d_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0]  bb_addr [3];
        logic         bb_src  [3];
        logic [127:0] bb_data [3];
        int           acc_cyc [3];
        int           nacc;
        int           nrsp;
        int           idx;
        logic         adv;
        vec_t         g;

        vt[0]  = mk(3'd0, 3'd4, 1'b1, B + 32'h20,  16'hFFFF, D1,    1'b0, 3'd0, 1'b0, 1'b0, '0);
        vt[1]  = mk(3'd4, 3'd4, 1'b1, B + 32'h20,  16'hFFFF, '0,    1'b0, 3'd1, 1'b0, 1'b0, D1);
        vt[2]  = mk(3'd1, 3'd4, 1'b0, B + 32'h20,  16'h000F, FF,    1'b0, 3'd0, 1'b0, 1'b0, '0);
        vt[3]  = mk(3'd4, 3'd4, 1'b0, B + 32'h20,  16'hFFFF, '0,    1'b0, 3'd1, 1'b0, 1'b0, W2);
        vt[4]  = mk(3'd0, 3'd4, 1'b1, B + 32'h3F0, 16'hFFFF, D2,    1'b0, 3'd0, 1'b0, 1'b0, '0);
        vt[5]  = mk(3'd4, 3'd4, 1'b0, B + 32'h400, 16'hFFFF, '0,    1'b0, 3'd1, 1'b1, 1'b1, '0);
        vt[6]  = mk(3'd0, 3'd4, 1'b1, B - 32'h10,  16'hFFFF, D3,    1'b0, 3'd0, 1'b1, 1'b0, '0);
        vt[7]  = mk(3'd4, 3'd4, 1'b1, B + 32'h3F0, 16'hFFFF, '0,    1'b0, 3'd1, 1'b0, 1'b0, D2);
        vt[8]  = mk(3'd4, 3'd2, 1'b0, B + 32'h22,  16'hFFFF, '0,    1'b0, 3'd1, 1'b1, 1'b1, '0);
        vt[9]  = mk(3'd4, 3'd2, 1'b1, B + 32'h24,  16'hFFFF, '0,    1'b0, 3'd1, 1'b0, 1'b0, W2);
        vt[10] = mk(3'd4, 3'd5, 1'b0, B + 32'h20,  16'hFFFF, '0,    1'b0, 3'd1, 1'b1, 1'b1, '0);
        vt[11] = mk(3'd2, 3'd2, 1'b1, B + 32'h20,  16'hFFFF, D3,    1'b0, 3'd0, 1'b1, 1'b0, '0);
        vt[12] = mk(3'd0, 3'd4, 1'b0, B + 32'h28,  16'hFFFF, D3,    1'b0, 3'd0, 1'b1, 1'b0, '0);
        vt[13] = mk(3'd4, 3'd4, 1'b0, B + 32'h20,  16'hFFFF, '0,    1'b0, 3'd1, 1'b0, 1'b0, W2);
        vt[14] = mk(3'd0, 3'd4, 1'b1, B + 32'h30,  16'hFFFF, D3,    1'b1, 3'd0, 1'b0, 1'b0, '0);
        vt[15] = mk(3'd4, 3'd3, 1'b1, B + 32'h30,  16'hFFFF, '0,    1'b0, 3'd1, 1'b0, 1'b0, D3);
        vt[16] = mk(3'd1, 3'd0, 1'b0, B + 32'h31,  16'h0002, 128'h5A00, 1'b0, 3'd0, 1'b0, 1'b0, '0);
        vt[17] = mk(3'd4, 3'd4, 1'b0, B + 32'h30,  16'hFFFF, '0,    1'b0, 3'd1, 1'b0, 1'b0, D3P);

        b0.a_valid = 1'b0; b0.a_opcode = '0; b0.a_param = '0; b0.a_size = '0; b0.a_source = '0;
        b0.a_address = '0; b0.a_mask = '0; b0.a_data = '0; b0.a_corrupt = 1'b0; b0.d_ready = 1'b0;
        b3.a_valid = 1'b0; b3.a_opcode = '0; b3.a_param = '0; b3.a_size = '0; b3.a_source = '0;
        b3.a_address = '0; b3.a_mask = '0; b3.a_data = '0; b3.a_corrupt = 1'b0; b3.d_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst a_ready", b0.a_ready, 1);
        chk("rst d_valid", b0.d_valid, 0);
        chk("rst d_fields", {b0.d_opcode, b0.d_param, b0.d_size, b0.d_source, b0.d_sink,
                             b0.d_denied, b0.d_corrupt}, 0);
        chk("rst d_data", b0.d_data, 0);
        chk("rst3 a_ready", b3.a_ready, 1);
        chk("rst3 d_valid", b3.d_valid, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 18; k++) txn0(vt[k], k);

        // Wait-state instance: write, then read back under 5 cycles of d_ready stall.
        txn3(mk(3'd0, 3'd4, 1'b1, B + 32'h40, 16'hFFFF, D2, 1'b0, 3'd0, 1'b0, 1'b0, '0), 0);
        txn3(mk(3'd4, 3'd4, 1'b0, B + 32'h40, 16'hFFFF, '0, 1'b0, 3'd1, 1'b0, 1'b0, D2), 5);

        // Back-to-back Gets with a_valid held and d_ready tied high.
        bb_addr[0] = B + 32'h20;  bb_src[0] = 1'b1; bb_data[0] = W2;
        bb_addr[1] = B + 32'h3F0; bb_src[1] = 1'b0; bb_data[1] = D2;
        bb_addr[2] = B + 32'h30;  bb_src[2] = 1'b1; bb_data[2] = D3P;
        nacc = 0; nrsp = 0; idx = 0; adv = 1'b0;
        @(negedge clk);
        g = mk(3'd4, 3'd4, bb_src[0], bb_addr[0], 16'hFFFF, '0, 1'b0, 3'd1, 1'b0, 1'b0, '0);
        drive0(g);
        b0.d_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (b0.a_valid && b0.a_ready && nacc < 3) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                adv = 1'b1;
            end
            @(negedge clk);
            if (b0.d_valid && nrsp < 3) begin
                chk($sformatf("b2b rsp%0d source", nrsp), b0.d_source, bb_src[nrsp]);
                chk($sformatf("b2b rsp%0d data", nrsp), b0.d_data, bb_data[nrsp]);
                nrsp++;
            end
            if (adv) begin
                adv = 1'b0;
                idx++;
                if (idx < 3) begin
                    g = mk(3'd4, 3'd4, bb_src[idx], bb_addr[idx], 16'hFFFF, '0, 1'b0, 3'd1,
                           1'b0, 1'b0, '0);
                    drive0(g);
                end else begin
                    b0.a_valid = 1'b0;
                end
            end
        end
        b0.d_ready = 1'b0;
        chk("b2b accepts", nacc, 3);
        chk("b2b responses", nrsp, 3);
        if (nacc == 3) begin
            chk("b2b gap01", acc_cyc[1] - acc_cyc[0], 2);
            chk("b2b gap12", acc_cyc[2] - acc_cyc[1], 2);
        end

        // Async reset while a response is pending.
        @(negedge clk);
        g = mk(3'd4, 3'd4, 1'b1, B + 32'h20, 16'hFFFF, '0, 1'b0, 3'd1, 1'b0, 1'b0, W2);
        drive0(g);
        @(negedge clk);
        b0.a_valid = 1'b0;
        chk("pre-rst d_valid", b0.d_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst d_valid", b0.d_valid, 0);
        chk("async rst a_ready", b0.a_ready, 1);
        chk("async rst d_data", b0.d_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        txn0(g, 100);
        txn0(mk(3'd4, 3'd4, 1'b0, B + 32'h3F0, 16'hFFFF, '0, 1'b0, 3'd1, 1'b0, 1'b0, D2), 101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
